mpw_qual_mc: RTL and testbench

Multi-channel minimum pulse-width qualifier with runtime-programmable thresholds, per-channel input synchronisers, edge-event strobes and glitch statistics. It sits between raw asynchronous control or status inputs (buttons, fault lines, handshake pins) and the synchronous logic that consumes them. It supersedes the single-channel, fixed-threshold qualifier: thresholds are now registers-driven ports, and rejected short pulses are reported and counted.

---
 rtl/mpw_qual_mc.sv | 106 ++++++++++
 tb/tb_mpw_qual_mc.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpw_qual_mc.sv
// Multi-channel minimum pulse-width qualifier: synchronises raw inputs, accepts a level
// only after a programmable run of stable samples, and reports/counts rejected pulses.
module mpw_qual_mc #(
  parameter int   NCH         = 4,
  parameter int   CW          = 8,
  parameter int   GW          = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    sig_i,
  input  logic [NCH-1:0]    en_i,
  input  logic [CW-1:0]     th_assert_i,
  input  logic [CW-1:0]     th_deassert_i,
  input  logic [NCH-1:0]    glitch_clr_i,
  output logic [NCH-1:0]    sig_o,
  output logic [NCH-1:0]    rise_o,
  output logic [NCH-1:0]    fall_o,
  output logic [NCH-1:0]    glitch_o,
  output logic [NCH*GW-1:0] glitch_cnt_o
);

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [GW-1:0] GCNT_MAX = {GW{1'b1}};
  localparam logic [CW-1:0] TH_MIN   = CW'(1);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   level_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          th_sel;
    logic [CW-1:0]          th_eff;
    logic [CW:0]            cnt_inc;
    logic                   differs;
    logic                   accept;
    logic                   reject;
    logic                   rise_q;
    logic                   fall_q;
    logic                   glitch_q;
    logic [GW-1:0]          gcnt_q;

    assign s = sync_q[SYNC_STAGES-1];

    // The threshold applied depends on the direction being qualified; zero acts as one.
    always_comb begin
      th_sel = level_q ? th_deassert_i : th_assert_i;
      th_eff = (th_sel == '0) ? TH_MIN : th_sel;
    end

    assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign differs = (s != level_q);
    assign accept  = en_i[c] && differs && (cnt_inc >= {1'b0, th_eff});
    assign reject  = en_i[c] && !differs && (cnt_q != '0);

    // The synchroniser keeps running regardless of the channel enable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {SYNC_STAGES{RST_VAL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i[c]};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q  <= RST_VAL;
        cnt_q    <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        rise_q   <= accept && s;
        fall_q   <= accept && !s;
        glitch_q <= reject;
        if (accept) begin
          level_q <= s;
        end
        if (!en_i[c] || accept || reject) begin
          cnt_q <= '0;
        end else if (differs && (cnt_q != CNT_MAX)) begin
          cnt_q <= cnt_inc[CW-1:0];
        end
      end
    end

    // Clear takes priority over a coincident rejected pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gcnt_q <= '0;
      end else if (glitch_clr_i[c]) begin
        gcnt_q <= '0;
      end else if (reject && (gcnt_q != GCNT_MAX)) begin
        gcnt_q <= gcnt_q + GW'(1);
      end
    end

    assign sig_o[c]                 = level_q;
    assign rise_o[c]                = rise_q;
    assign fall_o[c]                = fall_q;
    assign glitch_o[c]              = glitch_q;
    assign glitch_cnt_o[c*GW +: GW] = gcnt_q;
  end

endmodule

// File: tb/tb_mpw_qual_mc.sv
// Bench for mpw_qual_mc: directed scenarios with constant expectations, then randomized
// traffic against a per-channel behavioural model of the qualification rules.
module tb_mpw_qual_mc;

  localparam int NCH  = 4;
  localparam int CW   = 4;
  localparam int GW   = 2;
  localparam int SS   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int GMAX = (1 << GW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    sig_i;
  logic [NCH-1:0]    en_i;
  logic [CW-1:0]     tha;
  logic [CW-1:0]     thd;
  logic [NCH-1:0]    glitch_clr_i;
  logic [NCH-1:0]    sig_o;
  logic [NCH-1:0]    rise_o;
  logic [NCH-1:0]    fall_o;
  logic [NCH-1:0]    glitch_o;
  logic [NCH*GW-1:0] glitch_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  mpw_qual_mc #(
    .NCH(NCH), .CW(CW), .GW(GW), .SYNC_STAGES(SS), .RST_VAL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_i(sig_i), .en_i(en_i),
    .th_assert_i(tha), .th_deassert_i(thd), .glitch_clr_i(glitch_clr_i),
    .sig_o(sig_o), .rise_o(rise_o), .fall_o(fall_o), .glitch_o(glitch_o),
    .glitch_cnt_o(glitch_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic o;
    logic r;
    logic f;
    logic gl;
    int   run;
    int   g;
  } ch_res_t;

  function automatic ch_res_t step_ch(input logic s, input logic o, input int run, input int g,
                                      input logic en, input logic clr, input int tha_v,
                                      input int thd_v);
    ch_res_t res;
    int th;
    th = o ? thd_v : tha_v;
    if (th == 0) th = 1;
    res = '0;
    res.o = o;
    res.run = run;
    res.g = g;
    if (!en) begin
      res.run = 0;
    end else if (s == o) begin
      if (run > 0) begin
        res.gl = 1'b1;
        res.run = 0;
        res.g = (g < GMAX) ? g + 1 : GMAX;
      end
    end else if (run + 1 >= th) begin
      res.o = s;
      res.run = 0;
      res.r = s;
      res.f = !s;
    end else begin
      res.run = (run < CMAX) ? run + 1 : CMAX;
    end
    if (clr) res.g = 0;
    return res;
  endfunction

  logic [NCH-1:0] m_hist [SS];
  logic [NCH-1:0] m_out, m_rise, m_fall, m_glitch;
  int             m_run  [NCH];
  int             m_gcnt [NCH];
  ch_res_t        m_nxt  [NCH];

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      m_nxt[c] = step_ch(m_hist[SS-1][c], m_out[c], m_run[c], m_gcnt[c], en_i[c],
                         glitch_clr_i[c], int'(tha), int'(thd));
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SS; k++) m_hist[k] <= '0;
      m_out <= '0; m_rise <= '0; m_fall <= '0; m_glitch <= '0;
      for (int c = 0; c < NCH; c++) begin
        m_run[c]  <= 0;
        m_gcnt[c] <= 0;
      end
    end else begin
      for (int k = SS - 1; k > 0; k--) m_hist[k] <= m_hist[k-1];
      m_hist[0] <= sig_i;
      for (int c = 0; c < NCH; c++) begin
        m_out[c]    <= m_nxt[c].o;
        m_rise[c]   <= m_nxt[c].r;
        m_fall[c]   <= m_nxt[c].f;
        m_glitch[c] <= m_nxt[c].gl;
        m_run[c]    <= m_nxt[c].run;
        m_gcnt[c]   <= m_nxt[c].g;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [GW-1:0] gcnt(input int c);
    return glitch_cnt_o[c*GW +: GW];
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int falls;
    rst_n = 1'b0; sig_i = '1; en_i = '1; glitch_clr_i = '0; tha = 4'd3; thd = 4'd3;
    tick(3);
    n_cmp++;
    if ({sig_o, rise_o, fall_o, glitch_o} !== '0 || glitch_cnt_o !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got sig %b rise %b fall %b gl %b cnt %h expected all 0",
               sig_o, rise_o, fall_o, glitch_o, glitch_cnt_o);
    end
    sig_i = '0; rst_n = 1'b1;
    tick(4);
    n_cmp++;
    if (sig_o !== 4'b0000) begin
      n_err++; $display("FAIL idle_after_release: got %b expected 0000", sig_o);
    end
    sig_i[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++;
      if ({sig_o[0], rise_o[0]} !== {1'(k >= 5), 1'(k == 5)}) begin
        n_err++;
        $display("FAIL assert_latency edge %0d: got sig %b rise %b expected sig %b rise %b",
                 k, sig_o[0], rise_o[0], k >= 5, k == 5);
      end
    end
    sig_i[0] = 1'b0;
    falls = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      falls += int'(fall_o[0]);
    end
    n_cmp++;
    if (falls != 1 || sig_o[0] !== 1'b0) begin
      n_err++; $display("FAIL deassert_ch0: got falls %0d sig %b expected 1 0", falls, sig_o[0]);
    end
  endtask

  task automatic test_glitch();
    int gl, hi, ri, fa;
    tha = 4'd4; thd = 4'd2;
    sig_i[1] = 1'b1; tick(3); sig_i[1] = 1'b0;
    gl = 0; hi = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      gl += int'(glitch_o[1]);
      hi += int'(sig_o[1]);
    end
    n_cmp++;
    if (gl != 1 || hi != 0 || gcnt(1) !== 2'd1) begin
      n_err++;
      $display("FAIL glitch_3cyc: got strobes %0d high %0d cnt %0d expected 1 0 1", gl, hi, gcnt(1));
    end
    sig_i[1] = 1'b1; tick(4); sig_i[1] = 1'b0;
    gl = 0; ri = 0; fa = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      gl += int'(glitch_o[1]); ri += int'(rise_o[1]); fa += int'(fall_o[1]);
    end
    n_cmp++;
    if (ri != 1 || fa != 1 || gl != 0 || sig_o[1] !== 1'b0 || gcnt(1) !== 2'd1) begin
      n_err++;
      $display("FAIL accept_4cyc: got rise %0d fall %0d gl %0d sig %b cnt %0d expected 1 1 0 0 1",
               ri, fa, gl, sig_o[1], gcnt(1));
    end
  endtask

  task automatic test_threshold();
    int gl, ri, fa;
    tha = 4'd0; thd = 4'd1;
    sig_i[2] = 1'b1; tick(); sig_i[2] = 1'b0;
    gl = 0; ri = 0; fa = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      gl += int'(glitch_o[2]); ri += int'(rise_o[2]); fa += int'(fall_o[2]);
    end
    n_cmp++;
    if (ri != 1 || fa != 1 || gl != 0 || sig_o[2] !== 1'b0) begin
      n_err++;
      $display("FAIL th_zero_pulse: got rise %0d fall %0d gl %0d sig %b expected 1 1 0 0",
               ri, fa, gl, sig_o[2]);
    end
    tha = 4'd10; thd = 4'd2;
    sig_i[3] = 1'b1; tick(7);
    n_cmp++;
    if (sig_o[3] !== 1'b0) begin
      n_err++; $display("FAIL live_before: got %b expected 0", sig_o[3]);
    end
    tha = 4'd2; tick();
    n_cmp++;
    if ({sig_o[3], rise_o[3]} !== 2'b11) begin
      n_err++; $display("FAIL live_lowered: got sig %b rise %b expected 1 1", sig_o[3], rise_o[3]);
    end
    sig_i[3] = 1'b0; tick(6);
    n_cmp++;
    if (sig_o[3] !== 1'b0) begin
      n_err++; $display("FAIL live_deassert: got %b expected 0", sig_o[3]);
    end
  endtask

  task automatic test_enable_clear();
    int strobes, hi;
    tha = 4'd8; thd = 4'd2;
    sig_i[2] = 1'b1; tick(5);
    en_i[2] = 1'b0;
    strobes = 0; hi = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 6) sig_i[2] = 1'b0;
      if (k == 12) en_i[2] = 1'b1;
      tick();
      strobes += int'(rise_o[2]) + int'(fall_o[2]) + int'(glitch_o[2]);
      hi += int'(sig_o[2]);
    end
    n_cmp++;
    if (strobes != 0 || hi != 0 || gcnt(2) !== 2'd0) begin
      n_err++;
      $display("FAIL disable_midcount: got strobes %0d high %0d cnt %0d expected 0 0 0",
               strobes, hi, gcnt(2));
    end
    tha = 4'd4;
    sig_i[1] = 1'b1; tick(2); sig_i[1] = 1'b0; tick(2);
    glitch_clr_i[1] = 1'b1; tick();
    n_cmp++;
    if (glitch_o[1] !== 1'b1 || gcnt(1) !== 2'd0) begin
      n_err++;
      $display("FAIL clear_vs_glitch: got gl %b cnt %0d expected 1 0", glitch_o[1], gcnt(1));
    end
    glitch_clr_i[1] = 1'b0; tick();
    n_cmp++;
    if (glitch_o[1] !== 1'b0 || gcnt(1) !== 2'd0) begin
      n_err++;
      $display("FAIL clear_after: got gl %b cnt %0d expected 0 0", glitch_o[1], gcnt(1));
    end
  endtask

  task automatic test_saturation();
    tha = 4'd4;
    for (int i = 0; i < 5; i++) begin
      sig_i[0] = 1'b1; tick(2); sig_i[0] = 1'b0; tick(4);
    end
    n_cmp++;
    if (gcnt(0) !== 2'd3) begin
      n_err++; $display("FAIL glitch_saturate: got %0d expected 3", gcnt(0));
    end
    tha = 4'd15; thd = 4'd1;
    sig_i[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 16 || k == 17) begin
        n_cmp++;
        if ({sig_o[0], rise_o[0]} !== {1'(k == 17), 1'(k == 17)}) begin
          n_err++;
          $display("FAIL th_max edge %0d: got sig %b rise %b expected %b %b",
                   k, sig_o[0], rise_o[0], k == 17, k == 17);
        end
      end
    end
    sig_i[0] = 1'b0; tick(4);
    n_cmp++;
    if (sig_o[0] !== 1'b0) begin
      n_err++; $display("FAIL th_max_release: got %b expected 0", sig_o[0]);
    end
  endtask

  task automatic test_random();
    logic [NCH*GW-1:0] exp_g;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 301) rst_n = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) sig_i[c] = ~sig_i[c];
        en_i[c] = ($urandom_range(0, 15) != 0);
        glitch_clr_i[c] = ($urandom_range(0, 31) == 0);
      end
      if (cyc % 40 == 0) begin
        tha = CW'($urandom_range(0, 6));
        thd = CW'($urandom_range(0, 6));
      end
      if (cyc == 300) begin
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sig_o, rise_o, fall_o, glitch_o} !== '0 || glitch_cnt_o !== '0) begin
          n_err++;
          $display("FAIL async_reset_midrun: got sig %b rise %b fall %b gl %b cnt %h expected 0",
                   sig_o, rise_o, fall_o, glitch_o, glitch_cnt_o);
        end
      end
      tick();
      for (int c = 0; c < NCH; c++) exp_g[c*GW +: GW] = GW'(m_gcnt[c]);
      n_cmp++;
      if (sig_o !== m_out || rise_o !== m_rise || fall_o !== m_fall ||
          glitch_o !== m_glitch || glitch_cnt_o !== exp_g) begin
        n_err++;
        $display("FAIL random cyc %0d: got sig %b rise %b fall %b gl %b cnt %h expected %b %b %b %b %h",
                 cyc, sig_o, rise_o, fall_o, glitch_o, glitch_cnt_o,
                 m_out, m_rise, m_fall, m_glitch, exp_g);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_threshold();
    test_enable_clear();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
